fetch_unit: RTL

Instruction fetch stage of the RISC-V core. It owns the fetch program counter, issues word-aligned read requests to instruction memory over a valid/ready channel, and buffers returned instructions with their PCs in a small in-order queue. Decode drains the queue through a valid/ready handshake. A single-cycle redirect from branch/jump resolution retargets the PC, flushes the queue and discards responses still in flight.

---
 rtl/fetch_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited requests to
// instruction memory and buffers in-order responses for decode; redirect flushes.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   pend_q, pend_d;
    logic [CW-1:0]   stale_q, stale_d;
    logic [CW-1:0]   count_q, count_d;

    logic [XLEN-1:0] aq_pc_q [DEPTH];
    logic [AW-1:0]   aq_wr_q, aq_wr_d;
    logic [AW-1:0]   aq_rd_q, aq_rd_d;

    logic [XLEN-1:0] iq_pc_q   [DEPTH];
    logic [31:0]     iq_data_q [DEPTH];
    logic [AW-1:0]   iq_wr_q, iq_wr_d;
    logic [AW-1:0]   iq_rd_q, iq_rd_d;

    logic [CW:0] used;
    logic        issue;
    logic        resp;
    logic        push;
    logic        pop;

    // Stale requests still hold credit, so pend and count together bound the queue.
    assign used           = {1'b0, pend_q} + {1'b0, count_q};
    assign imem_req_valid = !rst && !redirect_valid && (used < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc_q;

    assign issue = imem_req_valid && imem_req_ready;
    assign resp  = imem_resp_valid;
    assign push  = resp && (stale_q == '0) && !redirect_valid;
    assign pop   = inst_valid && inst_ready;

    assign inst_valid = (count_q != '0);
    assign inst_pc    = iq_pc_q[iq_rd_q];
    assign inst_data  = iq_data_q[iq_rd_q];

    always_comb begin
        pc_d     = pc_q;
        pend_d   = pend_q + CW'(issue) - CW'(resp);
        stale_d  = stale_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        aq_wr_d  = aq_wr_q + AW'(issue);
        aq_rd_d  = aq_rd_q + AW'(resp);
        iq_wr_d  = iq_wr_q + AW'(push);
        iq_rd_d  = iq_rd_q + AW'(pop);

        if (issue) begin
            pc_d = pc_q + XLEN'(4);
        end
        if (resp && (stale_q != '0)) begin
            stale_d = stale_q - CW'(1);
        end

        if (redirect_valid) begin
            pc_d    = redirect_pc & ~XLEN'(3);
            // No issue this cycle, so whatever remains outstanding is stale.
            stale_d = pend_q - CW'(resp);
            count_d = '0;
            iq_wr_d = '0;
            iq_rd_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            stale_q <= '0;
            count_q <= '0;
            aq_wr_q <= '0;
            aq_rd_q <= '0;
            iq_wr_q <= '0;
            iq_rd_q <= '0;
        end else begin
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            stale_q <= stale_d;
            count_q <= count_d;
            aq_wr_q <= aq_wr_d;
            aq_rd_q <= aq_rd_d;
            iq_wr_q <= iq_wr_d;
            iq_rd_q <= iq_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            aq_pc_q[aq_wr_q] <= pc_q;
        end
        if (push) begin
            iq_pc_q[iq_wr_q]   <= aq_pc_q[aq_rd_q];
            iq_data_q[iq_wr_q] <= imem_resp_data;
        end
    end

endmodule
